// File: rtl/frodo_pkg.sv
// rtl/frodo_pkg.sv - shared state encodings, mode codes and default program tables
// for the FrodoKEM instruction sequencer.
package frodo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_IF,
    ST_EX,
    ST_FINISH
  } state_e;

  localparam logic [1:0] MODE_KEYGEN = 2'd0;
  localparam logic [1:0] MODE_ENCAP  = 2'd1;
  localparam logic [1:0] MODE_DECAP  = 2'd2;

  // Per-mode pc tables, mode 3 in the top byte down to mode 0 in the bottom byte.
  localparam logic [31:0] DEF_START_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_END_PC   = {8'd0, 8'd2, 8'd17, 8'd7};

endpackage

// File: rtl/frodo_watchdog.sv
// rtl/frodo_watchdog.sv - execute-phase watchdog; expire fires on the enabled cycle
// whose increment would bring the counter to all-ones.
module frodo_watchdog #(
  parameter int TMO_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire = enable & ~clear & (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frodo_seq_ctrl.sv
// rtl/frodo_seq_ctrl.sv - FrodoKEM program sequencer: steps pc from the mode's first
// to last instruction, issuing one inst_valid pulse per instruction.
module frodo_seq_ctrl
  import frodo_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int MODE_W = 2,
  parameter int LVL_W  = 2,
  parameter int TMO_W  = 16,
  parameter logic [(2**MODE_W)*PC_W-1:0] START_PC = DEF_START_PC,
  parameter logic [(2**MODE_W)*PC_W-1:0] END_PC   = DEF_END_PC,
  parameter logic [(2**MODE_W)-1:0]      MODE_EN  = 4'b0111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LVL_W-1:0]  level,
  input  logic [MODE_W-1:0] mode,
  input  logic              start,
  input  logic              abort,
  input  logic              inst_done,
  output logic              valid,
  output logic              err,
  output logic              busy,
  output logic              inst_valid,
  output logic [LVL_W-1:0]  level_reg,
  output logic [MODE_W-1:0] mode_reg,
  output logic [PC_W-1:0]   pc
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [LVL_W-1:0]  level_reg_q, level_reg_d;
  logic [MODE_W-1:0] mode_reg_q, mode_reg_d;
  logic              valid_q, valid_d, err_q, err_d;
  logic              busy_q, busy_d, inst_valid_q, inst_valid_d;
  logic              start_d_q, start_d_d, armed_q, armed_d;
  logic              start_pos, wd_clear, wd_en, wd_expire;
  logic [PC_W-1:0]   start_pc_sel, end_pc_sel;

  assign start_pc_sel = START_PC[mode_reg_q*PC_W +: PC_W];
  assign end_pc_sel   = END_PC[mode_reg_q*PC_W +: PC_W];

  // armed stays low after reset until start has been seen low, so a start
  // held through reset release cannot launch a run.
  assign start_pos = start & ~start_d_q & armed_q;

  frodo_watchdog #(.TMO_W(TMO_W)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    level_reg_d  = level_reg_q;
    mode_reg_d   = mode_reg_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    inst_valid_d = 1'b0;
    wd_clear     = 1'b0;
    wd_en        = 1'b0;
    start_d_d    = start;
    armed_d      = armed_q | ~start;

    case (state_q)
      ST_IDLE: begin
        if (start_pos) begin
          if (MODE_EN[mode]) begin
            level_reg_d = level;
            mode_reg_d  = mode;
            state_d     = ST_START;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_START: begin
        pc_d    = start_pc_sel;
        state_d = ST_IF;
      end
      ST_IF: begin
        inst_valid_d = 1'b1;
        wd_clear     = 1'b1;
        state_d      = ST_EX;
      end
      ST_EX: begin
        wd_en = ~inst_done & ~abort;
        if (inst_done) begin
          state_d = ST_FINISH;
        end else if (wd_expire) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_FINISH: begin
        if (pc_q == end_pc_sel) begin
          state_d = ST_IDLE;
          valid_d = 1'b1;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = ST_IF;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) begin
      state_d      = ST_IDLE;
      pc_d         = pc_q;
      valid_d      = 1'b0;
      err_d        = 1'b0;
      inst_valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      level_reg_q  <= '0;
      mode_reg_q   <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      start_d_q    <= 1'b0;
      armed_q      <= ~start;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      level_reg_q  <= level_reg_d;
      mode_reg_q   <= mode_reg_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      inst_valid_q <= inst_valid_d;
      start_d_q    <= start_d_d;
      armed_q      <= armed_d;
    end
  end

  assign valid      = valid_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign inst_valid = inst_valid_q;
  assign level_reg  = level_reg_q;
  assign mode_reg   = mode_reg_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_frodo_seq_ctrl.sv
// tb/tb_frodo_seq_ctrl.sv - directed self-checking bench for frodo_seq_ctrl.
module tb_frodo_seq_ctrl;
  import frodo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, inst_done;
  logic [1:0] level, mode;

  logic       a_valid, a_err, a_busy, a_iv;
  logic [1:0] a_lvl, a_mode;
  logic [7:0] a_pc;
  logic       w_valid, w_err, w_busy, w_iv;
  logic [1:0] w_lvl, w_mode;
  logic [3:0] w_pc;

  logic       sel;
  logic       o_valid, o_err, o_busy, o_iv;
  logic [1:0] o_lvl, o_mode;
  logic [7:0] o_pc;

  frodo_seq_ctrl #(.TMO_W(4)) dut_a (
    .clk(clk), .rst(rst), .level(level), .mode(mode), .start(start),
    .abort(abort), .inst_done(inst_done), .valid(a_valid), .err(a_err),
    .busy(a_busy), .inst_valid(a_iv), .level_reg(a_lvl), .mode_reg(a_mode),
    .pc(a_pc)
  );

  frodo_seq_ctrl #(
    .PC_W(4),
    .START_PC({4'd14, 4'd14, 4'd14, 4'd14}),
    .END_PC({4'd1, 4'd1, 4'd1, 4'd1})
  ) dut_w (
    .clk(clk), .rst(rst), .level(level), .mode(mode), .start(start),
    .abort(abort), .inst_done(inst_done), .valid(w_valid), .err(w_err),
    .busy(w_busy), .inst_valid(w_iv), .level_reg(w_lvl), .mode_reg(w_mode),
    .pc(w_pc)
  );

  assign o_valid = sel ? w_valid : a_valid;
  assign o_err   = sel ? w_err : a_err;
  assign o_busy  = sel ? w_busy : a_busy;
  assign o_iv    = sel ? w_iv : a_iv;
  assign o_lvl   = sel ? w_lvl : a_lvl;
  assign o_mode  = sel ? w_mode : a_mode;
  assign o_pc    = sel ? {4'b0000, w_pc} : a_pc;

  int checks = 0;
  int errors = 0;
  int n_iv = 0, n_valid = 0, n_err = 0;
  int pc_log[$];

  always @(negedge clk) begin
    if (o_iv) begin
      n_iv++;
      pc_log.push_back(int'(o_pc));
    end
    if (o_valid) n_valid++;
    if (o_err) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // inst_done goes high three cycles after each inst_valid when with_done is set;
  // abort accompanies the inst_done issued while pc equals abort_pc.
  task automatic run(input bit with_done, input int abort_pc, input int max_c,
                     output int iv_c, output int end_c, output int abort_c);
    int cd;
    cd = -1; iv_c = -1; end_c = -1; abort_c = -1;
    for (int c = 0; c < max_c; c++) begin
      if (!o_busy) begin
        end_c = c;
        break;
      end
      if (o_iv) begin
        if (iv_c < 0) iv_c = c;
        if (with_done) cd = 3;
      end
      inst_done = 1'b0;
      abort     = 1'b0;
      if (cd == 0) begin
        inst_done = 1'b1;
        if (int'(o_pc) == abort_pc) begin
          abort   = 1'b1;
          abort_c = c;
        end
        cd = -1;
      end else if (cd > 0) begin
        cd--;
      end
      tick();
    end
    inst_done = 1'b0;
    abort     = 1'b0;
    check("run_terminates", end_c >= 0, 1);
  endtask

  int b_iv, b_v, b_e, b_log, iv_c, end_c, ab_c;

  initial begin
    sel = 1'b0; rst = 1'b1; start = 1'b0; abort = 1'b0; inst_done = 1'b0;
    level = 2'd0; mode = 2'd0;
    repeat (3) tick();
    check("rst_busy", a_busy, 0);
    check("rst_pc", a_pc, 0);
    check("rst_valid", a_valid, 0);
    check("rst_err", a_err, 0);
    check("rst_iv", a_iv, 0);
    check("rst_mode_reg", a_mode, 0);
    check("rst_level_reg", a_lvl, 0);
    rst = 1'b0;
    tick();

    // keygen, pc 0..7
    b_iv = n_iv; b_v = n_valid; b_e = n_err; b_log = pc_log.size();
    mode = MODE_KEYGEN; level = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("kg_busy", o_busy, 1);
    run(1'b1, -1, 400, iv_c, end_c, ab_c);
    check("kg_valid_with_idle", o_valid, 1);
    check("kg_pc_end", o_pc, 7);
    tick();
    check("kg_iv_count", n_iv - b_iv, 8);
    check("kg_valid_count", n_valid - b_v, 1);
    check("kg_err_count", n_err - b_e, 0);
    for (int i = 0; i < 8; i++)
      check("kg_pc_seq", (pc_log.size() > b_log + i) ? pc_log[b_log + i] : -1, i);
    check("kg_mode_reg", o_mode, 0);
    check("kg_level_reg", o_lvl, 2);

    // encap aborted together with inst_done at pc 5
    b_iv = n_iv; b_v = n_valid; b_e = n_err;
    mode = MODE_ENCAP; level = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    run(1'b1, 5, 400, iv_c, end_c, ab_c);
    check("ab_idle_next", end_c - ab_c, 1);
    check("ab_pc_hold", o_pc, 5);
    check("ab_no_valid", o_valid, 0);
    check("ab_no_err", o_err, 0);
    tick();
    check("ab_iv_count", n_iv - b_iv, 6);
    check("ab_valid_count", n_valid - b_v, 0);
    check("ab_err_count", n_err - b_e, 0);
    check("ab_mode_reg", o_mode, 1);

    // illegal mode 3
    b_e = n_err;
    mode = 2'd3; level = 2'd3; start = 1'b1; inst_done = 1'b1;
    tick();
    check("ill_err", o_err, 1);
    check("ill_busy", o_busy, 0);
    check("ill_mode_reg", o_mode, 1);
    check("ill_level_reg", o_lvl, 1);
    tick();
    check("ill_err_once", o_err, 0);
    check("ill_busy_after", o_busy, 0);
    start = 1'b0; inst_done = 1'b0;
    tick();
    check("ill_err_count", n_err - b_e, 1);

    // decap with no inst_done: watchdog expiry
    b_iv = n_iv; b_v = n_valid; b_e = n_err;
    mode = MODE_DECAP; level = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    run(1'b0, -1, 100, iv_c, end_c, ab_c);
    check("wd_ex_cycles", end_c - iv_c, 15);
    check("wd_err", o_err, 1);
    check("wd_no_valid", o_valid, 0);
    tick();
    check("wd_iv_count", n_iv - b_iv, 1);
    check("wd_valid_count", n_valid - b_v, 0);
    check("wd_err_count", n_err - b_e, 1);

    // start held high across completion and reset
    b_v = n_valid;
    mode = MODE_DECAP; start = 1'b1;
    tick();
    run(1'b1, -1, 200, iv_c, end_c, ab_c);
    check("rg_valid", o_valid, 1);
    check("rg_pc_end", o_pc, 2);
    repeat (4) tick();
    check("rg_no_rerun", o_busy, 0);
    check("rg_valid_count", n_valid - b_v, 1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rg_no_run_after_rst", o_busy, 0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("rg_new_edge_runs", o_busy, 1);

    // reset in the middle of that run
    b_v = n_valid; b_e = n_err;
    repeat (5) tick();
    check("mr_running", o_busy, 1);
    rst = 1'b1;
    tick();
    check("mr_busy", o_busy, 0);
    check("mr_pc", o_pc, 0);
    rst = 1'b0; start = 1'b0;
    repeat (3) tick();
    check("mr_valid_count", n_valid - b_v, 0);
    check("mr_err_count", n_err - b_e, 0);

    // pc wrap on the 4-bit instance: 14,15,0,1
    sel = 1'b1; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    b_iv = n_iv; b_v = n_valid; b_log = pc_log.size();
    mode = MODE_KEYGEN; start = 1'b1;
    tick();
    start = 1'b0;
    run(1'b1, -1, 200, iv_c, end_c, ab_c);
    check("wr_valid", o_valid, 1);
    check("wr_pc_end", o_pc, 1);
    tick();
    check("wr_iv_count", n_iv - b_iv, 4);
    check("wr_valid_count", n_valid - b_v, 1);
    check("wr_pc0", (pc_log.size() > b_log + 0) ? pc_log[b_log + 0] : -1, 14);
    check("wr_pc1", (pc_log.size() > b_log + 1) ? pc_log[b_log + 1] : -1, 15);
    check("wr_pc2", (pc_log.size() > b_log + 2) ? pc_log[b_log + 2] : -1, 0);
    check("wr_pc3", (pc_log.size() > b_log + 3) ? pc_log[b_log + 3] : -1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frodo_seq_ctrl.md
FRODO_SEQ_CTRL -- requirements
Module: frodo_seq_ctrl

Interface
REQ-001 Parameter PC_W, default 8: program-counter width.
REQ-002 Parameter MODE_W, default 2: mode field width; N_MODES = 2**MODE_W.
REQ-003 Parameter LVL_W, default 2: security-level field width.
REQ-004 Parameter TMO_W, default 16: EX watchdog counter width.
REQ-005 Parameter START_PC, N_MODES*PC_W bits, default all zero: first pc per mode; mode m occupies slice [m*PC_W +: PC_W].
REQ-006 Parameter END_PC, N_MODES*PC_W bits, default {0,2,17,7} (mode 3..0): last pc per mode.
REQ-007 Parameter MODE_EN, N_MODES bits, default 4'b0111: legal-mode mask.
REQ-008 clk  in  1  clock, all logic on rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 level  in  LVL_W  requested security level.
REQ-011 mode  in  MODE_W  requested operation (0 keygen, 1 encap, 2 decap).
REQ-012 start  in  1  run request; rising edge triggers.
REQ-013 abort  in  1  cancel running program.
REQ-014 inst_done  in  1  executing instruction finished.
REQ-015 valid  out  1  one-cycle pulse, program completed.
REQ-016 err  out  1  one-cycle pulse, illegal mode or watchdog expiry.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 inst_valid  out  1  one-cycle instruction-issue pulse.
REQ-019 level_reg  out  LVL_W  latched level.
REQ-020 mode_reg  out  MODE_W  latched mode.
REQ-021 pc  out  PC_W  current instruction index.

Function
REQ-022 FSM states IDLE, START, IF, EX, FINISH; all outputs registered.
REQ-023 start_d SHALL register start every cycle; start_pos = start & ~start_d.
REQ-024 IDLE: on start_pos with MODE_EN[mode]=1, latch level/mode into level_reg/mode_reg and go START; otherwise stay.
REQ-025 IDLE: on start_pos with MODE_EN[mode]=0, stay IDLE, pulse err next cycle, level_reg/mode_reg unchanged.
REQ-026 start_pos outside IDLE SHALL be ignored (no queuing).
REQ-027 START: pc <= START_PC[mode_reg]; next IF.
REQ-028 IF: inst_valid <= 1 (high during first EX cycle only); watchdog cleared; next EX.
REQ-029 EX: inst_done -> FINISH; watchdog increments each EX cycle without inst_done.
REQ-030 EX: watchdog reaching all-ones without inst_done -> IDLE, err pulse, no valid.
REQ-031 FINISH: pc == END_PC[mode_reg] -> IDLE, valid pulse in first IDLE cycle, pc holds; else pc <= pc+1 modulo 2**PC_W, next IF.
REQ-032 pc wrap SHALL be permitted: END_PC below START_PC runs through wrap.
REQ-033 abort in any non-IDLE state -> IDLE next cycle; abort outranks inst_done and watchdog; no valid, no err.
REQ-034 inst_done outside EX SHALL be ignored.
REQ-035 pc SHALL hold its last value in IDLE until next START.
REQ-036 Instruction count per run = END_PC-START_PC+1 (mod 2**PC_W), each with exactly one inst_valid pulse.

Reset
REQ-037 rst SHALL force state IDLE, pc 0, level_reg 0, mode_reg 0, valid/err/inst_valid/busy 0, start_d 0, watchdog 0.
REQ-038 rst mid-run SHALL abandon the program with no valid or err pulse.
REQ-039 start held high through reset release SHALL NOT trigger a run (start_d clears to 0, then needs a low-to-high edge… start_d samples high first cycle: edge only after start returns low).

Structure
REQ-040 State encodings, mode constants (KEYGEN/ENCAP/DECAP) and default START_PC/END_PC vectors SHALL live in shared package frodo_pkg.
REQ-041 Watchdog SHALL be one sub-module frodo_watchdog (clear, enable, expire).

Verification
REQ-042 Keygen: mode=0, start edge, inst_done 3 cycles after each inst_valid -> 8 inst_valid pulses, pc 0..7, one valid, busy falls with valid.
REQ-043 Encap with abort: mode=1, abort asserted with inst_done at pc=5 -> IDLE next cycle, no valid, no err, pc stays 5.
REQ-044 Illegal mode: mode=3, start edge -> err pulse once, busy stays 0, mode_reg unchanged.
REQ-045 Watchdog: TMO_W=4, decap, no inst_done -> err after 15 EX cycles, IDLE, no valid.
REQ-046 Wrap: PC_W=4, START_PC=14, END_PC=1 -> pc 14,15,0,1, four inst_valid, one valid.
REQ-047 Restart guard: start held high across completion and reset -> no second run until start falls and rises.
